// File: rtl/debug_scan_master_pkg.sv
// Shared types and constants for the debug scan master: FSM state encoding,
// default DR shift length and the debug slave's IR encodings.
package debug_scan_master_pkg;

  localparam int unsigned SR_W_DEF = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACE     = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } state_e;

endpackage

// File: rtl/debug_scan_tck_gen.sv
// TCK divider: TCK_HALF clk cycles low then TCK_HALF high per period, with
// strobes flagging the clk edges on which TCK falls (period start) and rises.
module debug_scan_tck_gen #(
  parameter int unsigned TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic tck_fall,
  output logic tck_rise
);

  localparam int unsigned   HW        = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(TCK_HALF - 1);

  // half_q/phase_q name the half-period slot that the next clk edge opens.
  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic          tck_q, tck_d;

  assign tck_fall = run && !phase_q && (half_q == '0);
  assign tck_rise = run &&  phase_q && (half_q == '0);
  assign tck      = tck_q;

  always_comb begin
    half_d  = half_q;
    phase_d = phase_q;
    tck_d   = tck_q;
    if (!run) begin
      half_d  = '0;
      phase_d = 1'b0;
      tck_d   = 1'b0;
    end else begin
      if (half_q == HALF_LAST) begin
        half_d  = '0;
        phase_d = ~phase_q;
      end else begin
        half_d = half_q + 1'b1;
      end
      if (tck_fall) begin
        tck_d = 1'b0;
      end else if (tck_rise) begin
        tck_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_q  <= '0;
      phase_q <= 1'b0;
      tck_q   <= 1'b0;
    end else begin
      half_q  <= half_d;
      phase_q <= phase_d;
      tck_q   <= tck_d;
    end
  end

endmodule

// File: rtl/debug_scan_master.sv
// Virtual-JTAG scan initiator: runs UIR->CDR->SDR->UDR->RTI for one command.
// Optional DEBUG_SCAN_SKIP_IR_EN skips UIR when the held IR already matches.
module debug_scan_master
  import debug_scan_master_pkg::*;
#(
  parameter int unsigned SR_W       = SR_W_DEF,
  parameter int unsigned TCK_HALF   = 2,
  parameter int unsigned RTI_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_ir,
  input  logic [SR_W-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SR_W-1:0] rsp_data,
  output logic [1:0]      rsp_ir_out,
  output logic            busy,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [1:0]      vji_ir_in,
  input  logic [1:0]      vji_ir_out,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  localparam int unsigned   BW       = $clog2(SR_W);
  localparam int unsigned   RW       = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(SR_W - 1);
  localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [SR_W-1:0] shift_q, shift_d;
  logic [SR_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]      ir_q, ir_d;
  logic [1:0]      ir_in_q, ir_in_d;
  logic [1:0]      ir_out_q, ir_out_d;
  logic            tdi_q, tdi_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [RW-1:0]   rti_q, rti_d;
  logic            run, tck_fall, tck_rise, accept, skip_ir;
`ifdef DEBUG_SCAN_SKIP_IR_EN
  logic            ir_vld_q, ir_vld_d;
`endif

  // pend_q covers the single cycle between accept and the first period start.
  assign cmd_ready  = (state_q == ST_IDLE) && !pend_q;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state_q != ST_IDLE);
  assign run        = pend_q || (busy && (state_q != ST_RESP));
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_ir_out = ir_out_q;
  assign vji_tdi    = tdi_q;
  assign vji_ir_in  = ir_in_q;
  assign vji_uir    = (state_q == ST_UIR);
  assign vji_cdr    = (state_q == ST_CDR);
  assign vji_sdr    = (state_q == ST_SDR);
  assign vji_udr    = (state_q == ST_UDR);
  assign vji_rti    = (state_q == ST_RTI);

  debug_scan_tck_gen #(
    .TCK_HALF (TCK_HALF)
  ) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .tck      (vji_tck),
    .tck_fall (tck_fall),
    .tck_rise (tck_rise)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    shift_d    = shift_q;
    rsp_data_d = rsp_data_q;
    ir_d       = ir_q;
    ir_in_d    = ir_in_q;
    ir_out_d   = ir_out_q;
    tdi_d      = tdi_q;
    bit_d      = bit_q;
    rti_d      = rti_q;
    skip_ir    = 1'b0;
`ifdef DEBUG_SCAN_SKIP_IR_EN
    ir_vld_d   = ir_vld_q;
    skip_ir    = ir_vld_q && (ir_q == ir_in_q);
`endif

    if (accept) begin
      pend_d  = 1'b1;
      shift_d = cmd_data;
      ir_d    = cmd_ir;
    end

    // Slave outputs are sampled mid-period, on the rising TCK edge.
    if (tck_rise) begin
      if (state_q == ST_UIR) begin
        ir_out_d = vji_ir_out;
      end
      if (state_q == ST_SDR) begin
        shift_d = {vji_tdo, shift_q[SR_W-1:1]};
      end
    end

    if (tck_fall) begin
      tdi_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          pend_d = 1'b0;
          if (skip_ir) begin
            state_d = ST_CDR;
          end else begin
            state_d = ST_UIR;
            ir_in_d = ir_q;
`ifdef DEBUG_SCAN_SKIP_IR_EN
            ir_vld_d = 1'b1;
`endif
          end
        end
        ST_UIR: state_d = ST_CDR;
        ST_CDR: begin
          state_d = ST_SDR;
          bit_d   = '0;
          tdi_d   = shift_q[0];
        end
        ST_SDR: begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_UDR;
          end else begin
            bit_d = bit_q + 1'b1;
            tdi_d = shift_q[0];
          end
        end
        ST_UDR: begin
          state_d = ST_RTI;
          rti_d   = '0;
        end
        ST_RTI: begin
          if (rti_q == RTI_LAST) begin
            state_d    = ST_RESP;
            rsp_data_d = shift_q;
          end else begin
            rti_d = rti_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if ((state_q == ST_RESP) && rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      shift_q    <= '0;
      rsp_data_q <= '0;
      ir_q       <= IR_OCIMEM;
      ir_in_q    <= IR_OCIMEM;
      ir_out_q   <= '0;
      tdi_q      <= 1'b0;
      bit_q      <= '0;
      rti_q      <= '0;
`ifdef DEBUG_SCAN_SKIP_IR_EN
      ir_vld_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      shift_q    <= shift_d;
      rsp_data_q <= rsp_data_d;
      ir_q       <= ir_d;
      ir_in_q    <= ir_in_d;
      ir_out_q   <= ir_out_d;
      tdi_q      <= tdi_d;
      bit_q      <= bit_d;
      rti_q      <= rti_d;
`ifdef DEBUG_SCAN_SKIP_IR_EN
      ir_vld_q   <= ir_vld_d;
`endif
    end
  end

endmodule

// File: tb/tb_debug_scan_master.sv
// Directed bench for debug_scan_master: a default-parameter instance with a
// 38-bit slave model, and a small fast instance (SR_W=4, TCK_HALF=1).
module tb_debug_scan_master;

`ifdef DEBUG_SCAN_SKIP_IR_EN
  localparam int LAT_SAME = 169;
  localparam int UIR_SAME = 0;
`else
  localparam int LAT_SAME = 173;
  localparam int UIR_SAME = 1;
`endif
  localparam int LAT_FULL  = 173;
  localparam int LAT_SMALL = 19;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [1:0]  cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
  logic [37:0] cmd_data, rsp_data;
  logic        vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic        s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready, s_busy;
  logic [1:0]  s_cmd_ir, s_rsp_ir_out, s_vji_ir_in, s_vji_ir_out;
  logic [3:0]  s_cmd_data, s_rsp_data;
  logic        s_vji_tck, s_vji_tdi, s_vji_tdo, s_vji_uir, s_vji_cdr, s_vji_sdr, s_vji_udr, s_vji_rti;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  debug_scan_master #(.SR_W(38), .TCK_HALF(2), .RTI_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
    .busy(busy), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  debug_scan_master #(.SR_W(4), .TCK_HALF(1), .RTI_CYCLES(2)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .rsp_ir_out(s_rsp_ir_out),
    .busy(s_busy), .vji_tck(s_vji_tck), .vji_tdi(s_vji_tdi), .vji_tdo(s_vji_tdo),
    .vji_ir_in(s_vji_ir_in), .vji_ir_out(s_vji_ir_out),
    .vji_uir(s_vji_uir), .vji_cdr(s_vji_cdr), .vji_sdr(s_vji_sdr), .vji_udr(s_vji_udr), .vji_rti(s_vji_rti)
  );

  // 38-bit slave model: capture pattern at CDR, shift LSB first during SDR.
  logic [37:0] msr = '0;
  logic [37:0] msr_at_udr = '0;
  int uir_pulses = 0;
  int sdr_rises = 0;
  always @(posedge vji_tck) begin
    if (vji_cdr) msr <= 38'h2A_5A5A_5A5A;
    else if (vji_sdr) begin
      msr <= {vji_tdi, msr[37:1]};
      sdr_rises <= sdr_rises + 1;
    end
  end
  always @(posedge vji_udr) msr_at_udr <= msr;
  always @(posedge vji_uir) uir_pulses <= uir_pulses + 1;
  assign vji_tdo    = msr[0];
  assign vji_ir_out = vji_uir ? 2'b01 : 2'b10;

  // 4-bit slave model with a log of the tdi bits seen per SDR period.
  logic [3:0] s_msr = '0;
  logic [3:0] s_tdi_log = '0;
  int s_sdr_n = 0;
  always @(posedge s_vji_tck) begin
    if (s_vji_cdr) s_msr <= 4'b0110;
    else if (s_vji_sdr) begin
      s_msr <= {s_vji_tdi, s_msr[3:1]};
      s_tdi_log[s_sdr_n % 4] <= s_vji_tdi;
      s_sdr_n <= s_sdr_n + 1;
    end
  end
  assign s_vji_tdo    = s_msr[0];
  assign s_vji_ir_out = s_vji_uir ? 2'b11 : 2'b00;

  // TCK period measurement on the small instance and strobe exclusivity on both.
  int cyc = 0;
  int s_last_rise = 0;
  int s_period = 0;
  int oh_err = 0;
  logic s_tck_prev = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (s_vji_tck && !s_tck_prev) begin
      s_period <= cyc - s_last_rise;
      s_last_rise <= cyc;
    end
    s_tck_prev <= s_vji_tck;
    if (busy && !rsp_valid) begin
      if (!$onehot({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti})) oh_err <= oh_err + 1;
    end else if ({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} != 5'b0) oh_err <= oh_err + 1;
    if (s_busy && !s_rsp_valid) begin
      if (!$onehot({s_vji_uir, s_vji_cdr, s_vji_sdr, s_vji_udr, s_vji_rti})) oh_err <= oh_err + 1;
    end else if ({s_vji_uir, s_vji_cdr, s_vji_sdr, s_vji_udr, s_vji_rti} != 5'b0) oh_err <= oh_err + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] ir, input logic [37:0] d, output int lat);
    cmd_ir = ir;
    cmd_data = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 1000) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({vji_tck, vji_tdi, vji_ir_in} !== 4'b0) begin bad++; $display("FAIL reset_vji got=%b exp=0000", {vji_tck, vji_tdi, vji_ir_in}); end
    total++; if ({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 5'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=00000", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}); end
    total++; if ({rsp_valid, rsp_ir_out} !== 3'b0 || rsp_data !== 38'h0) begin bad++; $display("FAIL reset_rsp got valid=%b ir=%b data=%h exp 0", rsp_valid, rsp_ir_out, rsp_data); end
    total++; if (s_cmd_ready !== 1'b1 || s_vji_tck !== 1'b0) begin bad++; $display("FAIL reset_small got ready=%b tck=%b exp 1/0", s_cmd_ready, s_vji_tck); end
  endtask

  task automatic test_scan();
    int lat, u0;
    u0 = uir_pulses;
    run_cmd(2'd2, 38'h15_1234_5678, lat);
    total++; if (lat != LAT_FULL) begin bad++; $display("FAIL scan_latency got=%0d exp=%0d", lat, LAT_FULL); end
    total++; if (rsp_data !== 38'h2A_5A5A_5A5A) begin bad++; $display("FAIL scan_rsp_data got=%h exp=2a5a5a5a5a", rsp_data); end
    total++; if (msr_at_udr !== 38'h15_1234_5678) begin bad++; $display("FAIL scan_slave_sr got=%h exp=1512345678", msr_at_udr); end
    total++; if (rsp_ir_out !== 2'b01) begin bad++; $display("FAIL scan_ir_out got=%b exp=01", rsp_ir_out); end
    total++; if (uir_pulses - u0 != 1) begin bad++; $display("FAIL scan_uir_pulses got=%0d exp=1", uir_pulses - u0); end
    total++; if (vji_tck !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL scan_resp_tck got tck=%b busy=%b exp 0/1", vji_tck, busy); end
  endtask

  task automatic test_backpressure();
    int viol, lat;
    viol = 0;
    cmd_ir = 2'd2;
    cmd_data = 38'h3F_0000_FFFF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!rsp_valid || cmd_ready || vji_tck || vji_uir) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles exp=0", viol); end
    total++; if (rsp_data !== 38'h2A_5A5A_5A5A) begin bad++; $display("FAIL bp_rsp_data got=%h exp=2a5a5a5a5a", rsp_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_release got valid=%b ready=%b exp 0/1", rsp_valid, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got ready=%b exp=0", cmd_ready); end
    lat = 0;
    while (!rsp_valid && lat < 1000) begin
      tick();
      lat++;
    end
    total++; if (lat != LAT_SAME) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT_SAME); end
    total++; if (msr_at_udr !== 38'h3F_0000_FFFF) begin bad++; $display("FAIL bp_slave_sr got=%h exp=3f0000ffff", msr_at_udr); end
    consume();
    tick();
    total++; if (vji_ir_in !== 2'b10 || rsp_ir_out !== 2'b01) begin bad++; $display("FAIL bp_ir_hold got ir_in=%b ir_out=%b exp 10/01", vji_ir_in, rsp_ir_out); end
  endtask

  task automatic test_skip_ir();
    int lat, u0;
    run_cmd(2'd3, 38'h00_0000_0001, lat);
    total++; if (lat != LAT_FULL) begin bad++; $display("FAIL skip_first_latency got=%0d exp=%0d", lat, LAT_FULL); end
    consume();
    u0 = uir_pulses;
    run_cmd(2'd3, 38'h20_0000_0000, lat);
    total++; if (lat != LAT_SAME) begin bad++; $display("FAIL skip_second_latency got=%0d exp=%0d", lat, LAT_SAME); end
    total++; if (uir_pulses - u0 != UIR_SAME) begin bad++; $display("FAIL skip_second_uir got=%0d exp=%0d", uir_pulses - u0, UIR_SAME); end
    total++; if (rsp_data !== 38'h2A_5A5A_5A5A || msr_at_udr !== 38'h20_0000_0000) begin bad++; $display("FAIL skip_second_data got rsp=%h sr=%h", rsp_data, msr_at_udr); end
    consume();
    u0 = uir_pulses;
    run_cmd(2'd0, 38'h0A_AAAA_AAAA, lat);
    total++; if (lat != LAT_FULL) begin bad++; $display("FAIL skip_change_latency got=%0d exp=%0d", lat, LAT_FULL); end
    total++; if (uir_pulses - u0 != 1) begin bad++; $display("FAIL skip_change_uir got=%0d exp=1", uir_pulses - u0); end
    consume();
    total++; if (vji_ir_in !== 2'b00) begin bad++; $display("FAIL skip_change_ir_in got=%b exp=00", vji_ir_in); end
  endtask

  task automatic test_small();
    int lat, n0;
    n0 = s_sdr_n;
    s_cmd_ir = 2'd1;
    s_cmd_data = 4'b1011;
    s_cmd_valid = 1'b1;
    tick();
    s_cmd_valid = 1'b0;
    lat = 0;
    while (!s_rsp_valid && lat < 1000) begin
      tick();
      lat++;
    end
    total++; if (lat != LAT_SMALL) begin bad++; $display("FAIL small_latency got=%0d exp=%0d", lat, LAT_SMALL); end
    total++; if (s_rsp_data !== 4'b0110) begin bad++; $display("FAIL small_rsp_data got=%b exp=0110", s_rsp_data); end
    total++; if (s_sdr_n - n0 != 4) begin bad++; $display("FAIL small_sdr_periods got=%0d exp=4", s_sdr_n - n0); end
    total++; if (s_tdi_log !== 4'b1011) begin bad++; $display("FAIL small_tdi_order got=%b exp=1011", s_tdi_log); end
    total++; if (s_period != 2) begin bad++; $display("FAIL small_tck_period got=%0d exp=2", s_period); end
    total++; if (s_rsp_ir_out !== 2'b11 || s_vji_ir_in !== 2'b01) begin bad++; $display("FAIL small_ir got out=%b in=%b exp 11/01", s_rsp_ir_out, s_vji_ir_in); end
    s_rsp_ready = 1'b1;
    tick();
    s_rsp_ready = 1'b0;
    total++; if (oh_err != 0) begin bad++; $display("FAIL strobe_onehot got=%0d bad cycles exp=0", oh_err); end
  endtask

  task automatic test_reset_mid_scan();
    int n, s0, cnt;
    s0 = sdr_rises;
    cmd_ir = 2'd1;
    cmd_data = 38'h1F_FFFF_FFFF;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while ((sdr_rises - s0) < 21 && n < 2000) begin
      tick();
      n++;
    end
    total++; if (vji_sdr !== 1'b1) begin bad++; $display("FAIL midrst_in_sdr got sdr=%b exp=1", vji_sdr); end
    #1;
    reset_n = 1'b0;
    #1;
    total++; if ({busy, vji_tck, vji_tdi, vji_sdr, vji_ir_in} !== 6'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_outputs got busy=%b tck=%b tdi=%b sdr=%b ir_in=%b ready=%b", busy, vji_tck, vji_tdi, vji_sdr, vji_ir_in, cmd_ready); end
    total++; if (rsp_valid !== 1'b0 || rsp_data !== 38'h0 || rsp_ir_out !== 2'b0) begin bad++; $display("FAIL midrst_rsp got valid=%b data=%h ir=%b exp 0", rsp_valid, rsp_data, rsp_ir_out); end
    #3;
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rsp_valid || busy) cnt++;
    end
    total++; if (cnt != 0) begin bad++; $display("FAIL midrst_no_resp got=%0d cycles exp=0", cnt); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_ir = 2'd0; cmd_data = '0; rsp_ready = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_ir = 2'd0; s_cmd_data = '0; s_rsp_ready = 1'b0;
    test_reset();
    test_scan();
    test_backpressure();
    test_skip_ir();
    test_small();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/debug_scan_master.md
Name: debug_scan_master

Overview:
- Scan-chain initiator for the CPU debug slave's virtual-JTAG port.
- Converts a single-word command (IR value plus 38-bit DR payload) into a complete UIR → CDR → SDR → UDR → RTI sequence on the vji_* signals, with a TCK divided from clk.
- Returns the 38 bits shifted out of the slave and the captured 2-bit IR status.
- Used for on-chip debug self-test and for a host-less monitor path; sits beside the debug slave in place of the sld_virtual_jtag_basic hub.

Parameters:
- SR_W, 38, DR shift length in bits (≥2).
- TCK_HALF, 2, clk cycles per TCK half-period (≥1).
- RTI_CYCLES, 2, TCK periods spent in RTI after UDR (≥1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_ir  in  2  IR value to load
- cmd_data  in  SR_W  DR payload, shifted LSB first
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_data  out  SR_W  bits shifted out of the slave
- rsp_ir_out  out  2  vji_ir_out sampled during UIR
- busy  out  1  state != IDLE
- vji_tck  out  1  divided TCK
- vji_tdi  out  1  serial data to slave
- vji_tdo  in  1  serial data from slave
- vji_ir_in  out  2  IR presented to slave, held between commands
- vji_ir_out  in  2  slave IR status
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state strobes

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - state IDLE; cmd_ready=1, busy=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0, all strobes 0.
  - rsp_valid=0, rsp_data=0, rsp_ir_out=0.
  - Reset mid-scan aborts immediately to these values; no response is produced.
- TCK generation:
  - A half-period counter (width clog2(TCK_HALF)) runs only while busy.
  - Each TCK period is TCK_HALF clk cycles low, then TCK_HALF cycles high.
  - TCK is 0 in IDLE and RESP.
- Edge rules:
  - All vji_* outputs and state transitions change only at period start, i.e. the clk edge where TCK goes low.
  - vji_tdo and vji_ir_out are sampled on the clk edge where TCK goes high.
- Accept: a handshake occurs on the edge where cmd_valid && cmd_ready.
  - shift register ← cmd_data; ir_reg ← cmd_ir.
  - The UIR period begins on the next edge.
- States (each lasts exactly one TCK period unless noted):
  - IDLE: waits for an accepted command.
  - UIR: vji_uir=1, vji_ir_in=cmd_ir; rsp_ir_out ← vji_ir_out at the rising TCK.
  - CDR: vji_cdr=1.
  - SDR: lasts SR_W periods with vji_sdr=1 and vji_tdi=shift[0]. At each rising TCK, shift ← {vji_tdo, shift[SR_W-1:1]}. A bit counter 0..SR_W-1 advances SDR to UDR after the last bit.
  - UDR: vji_udr=1, vji_tdi=0.
  - RTI: lasts RTI_CYCLES periods with vji_rti=1.
  - RESP: rsp_valid=1, rsp_data=shift; holds until rsp_ready, then returns to IDLE on the same edge.
- Latency: rsp_valid rises exactly (3+SR_W+RTI_CYCLES)·2·TCK_HALF+1 clk cycles after the accept edge. With defaults this is 173.
- Back-pressure:
  - cmd_valid arriving during busy or RESP is ignored; cmd_ready=0 there.
  - A new command can be accepted no earlier than the cycle after rsp_ready is sampled.
- Output hold: vji_ir_in keeps the last loaded IR in IDLE; it is never returned to 0 except by reset.
- Mutual exclusion: exactly one of uir/cdr/sdr/udr/rti is high while busy, and none in IDLE or RESP.

Optional Feature:
- Macro: DEBUG_SCAN_SKIP_IR_EN.
- Defined:
  - A valid flag tracks the last loaded IR; the flag is cleared by reset.
  - If the flag is set and cmd_ir equals the held vji_ir_in, UIR is skipped and CDR starts on the edge after accept.
  - rsp_ir_out then keeps its previous value, and latency shrinks by 2·TCK_HALF.
- Undefined: UIR is always executed and the valid flag logic is absent.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, UIR, CDR, SDR, UDR, RTI, RESP);
  - the default SR_W=38;
  - IR encoding constants (0=ocimem, 1=trace, 2=break, 3=tracectrl).
- One natural sub-module: debug_scan_tck_gen, the half-period counter producing tck, a tck_fall strobe and a tck_rise strobe.

Test Plan:
- Reset release → cmd_ready=1, all vji_* outputs 0, busy=0; assert reset_n low at SDR bit 20 → all outputs back to reset values within the same cycle, rsp_valid stays 0.
- Bench slave model (38-bit SR loaded with 0x2A_5A5A_5A5A at CDR), cmd_ir=2, cmd_data=0x15_1234_5678 → rsp_data=0x2A_5A5A_5A5A, model SR at UDR=0x15_1234_5678, rsp_valid exactly 173 clk after accept (defaults).
- Model drives vji_ir_out=2'b01 during UIR → rsp_ir_out=2'b01; vji_ir_in stays 2'b10 in IDLE afterwards.
- Hold rsp_ready=0 for 50 cycles with cmd_valid high → rsp_valid held, no second accept, TCK stays 0; rsp_ready=1 → IDLE, next accept one cycle later.
- TCK_HALF=1, SR_W=4 → TCK period 2 clk, exactly 4 sdr periods, tdi bit order 0,1,2,3 of cmd_data; strobes one-hot throughout (assertion).
- With DEBUG_SCAN_SKIP_IR_EN, two back-to-back commands with cmd_ir=3 → second has no vji_uir pulse and latency 169; change to cmd_ir=0 → UIR present again.
